// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit producing the HI/LO pair for MULT/MULTU/DIV/DIVU.
// One result bit per cycle: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_div_by_zero,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic                 is_div_q;
  logic                 neg_lo_q;
  logic                 neg_hi_q;
  logic                 dz_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic                 op_signed, op_div, div_zero;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, trial;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // Handshake: i_start is a request that is taken only while o_busy is low
  // (state IDLE); o_busy acts as the inverted ready and requests seen while it is high are dropped.
  assign op_signed = i_op[0];
  assign op_div    = i_op[1];
  assign div_zero  = op_div && (i_op_b == '0);
  assign a_mag     = (op_signed && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
  assign b_mag     = (op_signed && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = div_zero ? DONE : CALC;
      CALC:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // acc holds {upper product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
    trial   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    if (!is_div_q)
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    else if (!trial[WIDTH])
      acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
  end

  always_comb begin
    prod = neg_lo_q ? -acc_d : acc_d;
    if (!is_div_q) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_hi = neg_hi_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
      res_lo = neg_lo_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            cnt_q    <= '0;
            is_div_q <= op_div;
            dz_q     <= div_zero;
            neg_lo_q <= op_signed && (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
            if (div_zero) begin
              hi_q     <= i_op_a;
              lo_q     <= '1;
              neg_hi_q <= 1'b0;
            end else if (op_div) begin
              acc_q    <= {{WIDTH{1'b0}}, a_mag};
              opnd_q   <= b_mag;
              neg_hi_q <= op_signed && i_op_a[WIDTH-1];
            end else begin
              acc_q    <= {{WIDTH{1'b0}}, b_mag};
              opnd_q   <= a_mag;
              neg_hi_q <= 1'b0;
            end
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            hi_q  <= res_hi;
            lo_q  <= res_lo;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: dz_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign o_busy        = (state_q != IDLE);
  assign o_done        = (state_q == DONE);
  assign o_div_by_zero = dz_q && (state_q == DONE);
  assign o_hi          = hi_q;
  assign o_lo          = lo_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model with a per-cycle compare,
// plus directed operations whose results and latencies are written out by hand.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int cyc = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_op_a(a), .i_op_b(b), .o_busy(busy), .o_done(done),
    .o_hi(hi), .o_lo(lo), .o_div_by_zero(dz), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference arithmetic
  function automatic void model_calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                     output logic [W-1:0] h, output logic [W-1:0] l, output logic d);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    d = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
      2'b10: if (y == 0) begin d = 1'b1; h = x; l = '1; end
             else begin l = x / y; h = x % y; end
      default: if (y == 0) begin d = 1'b1; h = x; l = '1; end
               else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
    endcase
  endfunction

  // scoreboard: remaining busy cycles and queued expected HI/LO
  logic [W-1:0] exp_q[$];
  int           m_left = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         p_dz = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] h, l;
    logic d;
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; p_dz = 1'b0;
      exp_q.delete();
    end else begin
      if (m_left == 0) begin
        if (start) begin
          model_calc(op, a, b, h, l, d);
          exp_q.push_back(h);
          exp_q.push_back(l);
          p_dz = d;
          m_left = d ? 1 : W + 1;
        end
      end else begin
        m_left--;
      end
      if (m_left == 1 && exp_q.size() >= 2) begin
        m_hi = exp_q.pop_front();
        m_lo = exp_q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_left > 0);
    check("done", done, m_left == 1);
    check("div_by_zero", dz, (m_left == 1) && p_dz);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  // drivers
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int t0);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input int elat);
    int t0, lat;
    start_op(o, x, y, t0);
    wait_done(t0, lat);
    check({name, "_latency"}, lat, elat);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_dz"}, dz, elat == 1);
  endtask

  initial begin : stim
    int t0, lat;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);

    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33);
    run_op("mult_neg",  2'b01, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    run_op("multu_neg", 2'b00, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 33);
    run_op("mult_zero", 2'b01, 32'd0,        32'd5,        32'h00000000, 32'h00000000, 33);
    run_op("mult_min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33);
    run_op("div_neg",   2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run_op("div_negb",  2'b11, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    run_op("divu",      2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       33);
    run_op("div_ovf",   2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run_op("divu_zero", 2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1);
    run_op("div_zero",  2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1);
    run_op("divu_big",  2'b10, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 33);

    // start request while busy must be dropped
    start_op(2'b00, 32'd6, 32'd7, t0);
    while ((cyc - t0) < 9) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; a = 32'd99; b = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t0, lat);
    check("ignored_latency", lat, 33);
    check("ignored_hi", hi, 32'd0);
    check("ignored_lo", lo, 32'd42);
    repeat (5) @(negedge clk);
    check("ignored_no_second_done", done, 0);

    // reset mid-operation
    start_op(2'b10, 32'd1000, 32'd3, t0);
    while ((cyc - t0) < 15) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    run_op("after_reset", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 33);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
